fetch_queue: RTL

Instruction fetch queue between the instruction fetcher and the decoder. It captures each completed fetch (instruction word plus PC) when the fetcher raises its done flag, and returns a one-cycle acknowledge that drives the fetcher's `if_id_pipeline_valid` input. It buffers up to `DEPTH` entries in a circular FIFO and presents them to the decoder under a valid/ready handshake. A branch redirect discards every buffered and in-flight entry.

---
 rtl/fetch_queue.sv | 89 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetcher and decoder with flush.
// Optional FETCH_QUEUE_PERF_EN adds saturating stall/drop performance counters.
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int XLEN   = 64,
   parameter int INSN_W = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         fetcher_done,
   input  logic [63:0]                  fetch_data,
   input  logic [XLEN-1:0]              fetch_pc,
   output logic                         fetch_ack,
   input  logic                         flush,
   output logic                         dec_valid,
   output logic [INSN_W-1:0]            dec_instr,
   output logic [XLEN-1:0]              dec_pc,
   input  logic                         dec_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
`ifdef FETCH_QUEUE_PERF_EN
   output logic [31:0]                  perf_full_stall,
   output logic [31:0]                  perf_flush_drops,
`endif
   output logic                         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [INSN_W-1:0] insn_mem [DEPTH];
   logic [XLEN-1:0]   pc_mem   [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic              req, push, pop;

   // The ack cycle itself never counts as a request, which enforces the ack gap.
   assign req       = fetcher_done && !fetch_ack;
   assign full      = count == CW'(DEPTH);
   assign empty     = count == '0;
   assign dec_valid = !empty;
   assign push      = req && !full && !flush;
   assign pop       = dec_valid && dec_ready && !flush;
   assign dec_instr = empty ? '0 : insn_mem[rd_ptr];
   assign dec_pc    = empty ? '0 : pc_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         insn_mem[wr_ptr] <= fetch_data[INSN_W-1:0];
         pc_mem[wr_ptr]   <= fetch_pc;
      end
   end

   // A request seen on a flush edge is still acked so the fetcher's handshake completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         fetch_ack <= 1'b0;
      end else begin
         fetch_ack <= req && (!full || flush);
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [32:0] drop_sum;
   assign drop_sum = {1'b0, perf_flush_drops} + 33'(count) + 33'(req);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_full_stall  <= '0;
         perf_flush_drops <= '0;
      end else begin
         if (fetcher_done && full && !fetch_ack && perf_full_stall != '1)
            perf_full_stall <= perf_full_stall + 32'd1;
         if (flush)
            perf_flush_drops <= drop_sum[32] ? '1 : drop_sum[31:0];
      end
   end
`endif
endmodule
